mux8_arbiter: RTL and testbench
===============================

MUX8_ARBITER -- requirements
Module: mux8_arbiter

Interface
REQ-001 SHALL have parameter WIDTH, default 16, data width of each requester input and of the output.
REQ-002 SHALL have parameter MAX_BURST, default 4, maximum beats per grant; legal range 1..16.
REQ-003 SHALL have port clk, input, 1 bit, the only clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit, reset, synchronous and active-high.
REQ-005 SHALL have port req, input, 8 bits, request from requester i on bit i; held high for the whole transaction.
REQ-006 SHALL have port data_in, input, 8*WIDTH bits, requester i data on bits [i*WIDTH +: WIDTH].
REQ-007 SHALL have port out_ready, input, 1 bit, downstream accepts a beat when high together with out_valid.
REQ-008 SHALL have port gnt, output, 8 bits, one-hot grant (all-zero when no owner), registered.
REQ-009 SHALL have port sel, output, 3 bits, index of the current or most recent owner, registered; drives the 8:1 data mux.
REQ-010 SHALL have port out, output, WIDTH bits, data_in slice selected by sel (combinational mux after registered sel).
REQ-011 SHALL have port out_valid, output, 1 bit, beat valid.
REQ-012 SHALL have port busy, output, 1 bit, high in state XFER.

Function
REQ-013 SHALL implement a two-state FSM: ARB and XFER.
REQ-014 In ARB with req != 0, SHALL pick the winner as the first set req bit searching upward from ptr, wrapping 7->0.
REQ-015 On an ARB pick, SHALL load sel = winner, gnt = one-hot(winner), beat_cnt = 0 and enter XFER at the same edge; gnt is visible one cycle after req is first sampled high.
REQ-016 In ARB with req == 0, SHALL stay in ARB with gnt = 0 and sel, ptr unchanged.
REQ-017 out_valid SHALL equal (state == XFER) AND req[sel]; it is combinational from the registered state.
REQ-018 A beat SHALL transfer on any edge where out_valid AND out_ready; beat_cnt then increments.
REQ-019 In XFER, if a beat transfers and beat_cnt == MAX_BURST-1, SHALL return to ARB with gnt = 0 and ptr = sel+1 mod 8 (burst limit).
REQ-020 In XFER, if req[sel] == 0, SHALL return to ARB with gnt = 0 and ptr = sel+1 mod 8 (owner release); no beat transfers that cycle.
REQ-021 In XFER, if out_ready == 0, SHALL hold state, gnt, sel and beat_cnt; out SHALL track data_in of the owner.
REQ-022 Every grant SHALL be followed by exactly one ARB cycle (one dead cycle between owners), including re-grant to the same requester.
REQ-023 Requests from non-owners during XFER SHALL be ignored until the next ARB cycle; no pre-emption.
REQ-024 sel = 7 SHALL wrap ptr to 0; ptr SHALL be a 3-bit register.
REQ-025 gnt SHALL never have more than one bit set; gnt != 0 iff busy.
REQ-026 beat_cnt SHALL be wide enough for MAX_BURST-1 and SHALL never exceed it.

Reset
REQ-027 With rst high at an edge, SHALL force state = ARB, gnt = 0, sel = 0, ptr = 0, beat_cnt = 0, regardless of current state or inputs.
REQ-028 During and after reset, out_valid = 0 and busy = 0; out = data_in[0 +: WIDTH].
REQ-029 Reset mid-burst SHALL abort the transaction with no further beats; arbitration restarts from ptr = 0 on the first edge after rst falls.

Verification
REQ-030 Reset, then req = 8'h01, out_ready = 1, data_in slice 0 = 16'hA5A5 held -> gnt = 8'h01 one cycle later, 4 beats of A5A5, then gnt = 0 for one cycle, then re-grant to 0.
REQ-031 req = 8'hFF held, out_ready = 1 -> grants in order 0,1,...,7,0, each 4 beats, one dead cycle between, sel wraps 7->0.
REQ-032 req = 8'h24 with ptr = 3 -> grant to 5; requester 5 drops req after 2 beats -> ARB next cycle, then grant to 2 (wrap search).
REQ-033 Owner 1 granted, out_ready = 0 for 5 cycles -> out_valid = 1, beat_cnt stays 0, gnt stays 8'h02; out_ready = 1 -> 4 beats complete.
REQ-034 rst asserted at beat 2 of a grant to 6 -> next edge gnt = 0, sel = 0, busy = 0; with req = 8'h41 after release, winner = 0.
REQ-035 MAX_BURST = 1, req = 8'h03 held -> alternating grants 0,1,0,1 with one beat each and one ARB cycle between.

Source files
------------

// File: rtl/mux8_arbiter.sv
// mux8_arbiter: round-robin 8:1 burst arbiter with registered grant/select
// and a combinational data mux driven from the registered select.
module mux8_arbiter #(
    parameter int WIDTH     = 16,
    parameter int MAX_BURST = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [7:0]         req,
    input  logic [8*WIDTH-1:0] data_in,
    input  logic               out_ready,
    output logic [7:0]         gnt,
    output logic [2:0]         sel,
    output logic [WIDTH-1:0]   out,
    output logic               out_valid,
    output logic               busy
);
    localparam int CW = MAX_BURST > 1 ? $clog2(MAX_BURST) : 1;
    localparam logic [CW-1:0] LAST = CW'(MAX_BURST - 1);
    typedef enum logic {ARB, XFER} state_t;
    state_t        state_q;
    logic [7:0]    gnt_q;
    logic [2:0]    sel_q, ptr_q, win_d;
    logic [CW-1:0] cnt_q;
    // Scan downward so the requester closest to ptr (searching upward) wins last.
    always_comb begin
        win_d = ptr_q;
        for (int k = 7; k >= 0; k--)
            if (req[ptr_q + 3'(k)]) win_d = ptr_q + 3'(k);
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ARB;
            gnt_q   <= '0;
            sel_q   <= '0;
            ptr_q   <= '0;
            cnt_q   <= '0;
        end else if (state_q == ARB) begin
            gnt_q <= |req ? 8'b1 << win_d : '0;
            if (|req) begin
                sel_q   <= win_d;
                cnt_q   <= '0;
                state_q <= XFER;
            end
        end else if (!req[sel_q] || (out_ready && cnt_q == LAST)) begin
            state_q <= ARB;
            gnt_q   <= '0;
            ptr_q   <= sel_q + 3'd1;
        end else if (out_ready) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end
    assign gnt       = gnt_q;
    assign sel       = sel_q;
    assign busy      = state_q == XFER;
    assign out_valid = busy && req[sel_q];
    assign out       = data_in[sel_q*WIDTH +: WIDTH];
endmodule

// File: tb/tb_mux8_arbiter.sv
// tb_mux8_arbiter: directed scenario tasks against a MAX_BURST=4 instance
// and a MAX_BURST=1 instance sharing the same stimulus.
module tb_mux8_arbiter;
    logic         clk = 1'b0;
    logic         rst;
    logic [7:0]   req;
    logic [127:0] data_in;
    logic         out_ready;
    logic [7:0]   gnt, gnt1;
    logic [2:0]   sel, sel1;
    logic [15:0]  out, out1;
    logic         out_valid, out_valid1, busy, busy1;
    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    mux8_arbiter #(.WIDTH(16), .MAX_BURST(4)) dut (
        .clk(clk), .rst(rst), .req(req), .data_in(data_in), .out_ready(out_ready),
        .gnt(gnt), .sel(sel), .out(out), .out_valid(out_valid), .busy(busy)
    );

    mux8_arbiter #(.WIDTH(16), .MAX_BURST(1)) dut1 (
        .clk(clk), .rst(rst), .req(req), .data_in(data_in), .out_ready(out_ready),
        .gnt(gnt1), .sel(sel1), .out(out1), .out_valid(out_valid1), .busy(busy1)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        req = '0;
        out_ready = 1'b1;
        step();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        req = 8'hFF;
        out_ready = 1'b1;
        step();
        step();
        checks++;
        if (gnt !== 8'h00 || sel !== 3'd0 || busy !== 1'b0 || out_valid !== 1'b0) begin
            failures++;
            $display("FAIL reset_state gnt=%h sel=%0d busy=%b valid=%b want 00/0/0/0", gnt, sel, busy, out_valid);
        end
        checks++;
        if (out !== 16'hC000) begin
            failures++;
            $display("FAIL reset_out got=%h want=c000", out);
        end
        rst = 1'b0;
    endtask

    task automatic test_single();
        do_reset();
        data_in[15:0] = 16'hA5A5;
        req = 8'h01;
        step();
        for (int b = 0; b < 4; b++) begin
            checks++;
            if (gnt !== 8'h01 || out_valid !== 1'b1 || out !== 16'hA5A5) begin
                failures++;
                $display("FAIL single_beat%0d gnt=%h valid=%b out=%h want 01/1/a5a5", b, gnt, out_valid, out);
            end
            step();
        end
        checks++;
        if (gnt !== 8'h00 || busy !== 1'b0) begin
            failures++;
            $display("FAIL single_dead gnt=%h busy=%b want 00/0", gnt, busy);
        end
        step();
        checks++;
        if (gnt !== 8'h01 || busy !== 1'b1) begin
            failures++;
            $display("FAIL single_regrant gnt=%h busy=%b want 01/1", gnt, busy);
        end
    endtask

    task automatic test_round_robin();
        do_reset();
        req = 8'hFF;
        step();
        for (int k = 0; k < 9; k++) begin
            for (int b = 0; b < 4; b++) begin
                checks++;
                if (gnt !== 8'(1 << (k % 8)) || sel !== 3'(k % 8) || out !== 16'(16'hC000 + k % 8) || out_valid !== 1'b1) begin
                    failures++;
                    $display("FAIL rr_owner%0d_beat%0d gnt=%h sel=%0d out=%h valid=%b", k, b, gnt, sel, out, out_valid);
                end
                step();
            end
            checks++;
            if (gnt !== 8'h00 || busy !== 1'b0 || out_valid !== 1'b0) begin
                failures++;
                $display("FAIL rr_dead%0d gnt=%h busy=%b valid=%b want 00/0/0", k, gnt, busy, out_valid);
            end
            step();
        end
    endtask

    task automatic test_release_wrap();
        do_reset();
        req = 8'h04;
        step();
        for (int b = 0; b < 4; b++) step();
        req = 8'h24;
        step();
        checks++;
        if (gnt !== 8'h20 || sel !== 3'd5) begin
            failures++;
            $display("FAIL release_first gnt=%h sel=%0d want 20/5", gnt, sel);
        end
        step();
        step();
        req = 8'h04;
        #1;
        checks++;
        if (out_valid !== 1'b0) begin
            failures++;
            $display("FAIL release_valid got=%b want=0", out_valid);
        end
        step();
        checks++;
        if (gnt !== 8'h00 || busy !== 1'b0) begin
            failures++;
            $display("FAIL release_arb gnt=%h busy=%b want 00/0", gnt, busy);
        end
        step();
        checks++;
        if (gnt !== 8'h04 || sel !== 3'd2) begin
            failures++;
            $display("FAIL release_wrap gnt=%h sel=%0d want 04/2", gnt, sel);
        end
    endtask

    task automatic test_stall();
        do_reset();
        out_ready = 1'b0;
        req = 8'h02;
        step();
        for (int c = 0; c < 5; c++) begin
            data_in[31:16] = 16'(16'h0B00 + c);
            #1;
            checks++;
            if (gnt !== 8'h02 || out_valid !== 1'b1 || out !== 16'(16'h0B00 + c)) begin
                failures++;
                $display("FAIL stall%0d gnt=%h valid=%b out=%h want 02/1/%h", c, gnt, out_valid, out, 16'(16'h0B00 + c));
            end
            step();
        end
        out_ready = 1'b1;
        for (int b = 0; b < 3; b++) step();
        checks++;
        if (gnt !== 8'h02) begin
            failures++;
            $display("FAIL stall_beats3 gnt=%h want=02", gnt);
        end
        step();
        checks++;
        if (gnt !== 8'h00) begin
            failures++;
            $display("FAIL stall_beats4 gnt=%h want=00", gnt);
        end
        data_in[31:16] = 16'hC001;
    endtask

    task automatic test_reset_mid_burst();
        do_reset();
        req = 8'h40;
        step();
        checks++;
        if (gnt !== 8'h40) begin
            failures++;
            $display("FAIL midrst_grant gnt=%h want=40", gnt);
        end
        step();
        step();
        rst = 1'b1;
        step();
        checks++;
        if (gnt !== 8'h00 || sel !== 3'd0 || busy !== 1'b0 || out_valid !== 1'b0 || out !== 16'hC000) begin
            failures++;
            $display("FAIL midrst_abort gnt=%h sel=%0d busy=%b valid=%b out=%h", gnt, sel, busy, out_valid, out);
        end
        rst = 1'b0;
        req = 8'h41;
        step();
        checks++;
        if (gnt !== 8'h01 || sel !== 3'd0) begin
            failures++;
            $display("FAIL midrst_restart gnt=%h sel=%0d want 01/0", gnt, sel);
        end
    endtask

    task automatic test_burst1();
        logic [7:0] exp_g [7] = '{8'h01, 8'h00, 8'h02, 8'h00, 8'h01, 8'h00, 8'h02};
        do_reset();
        req = 8'h03;
        for (int c = 0; c < 7; c++) begin
            step();
            checks++;
            if (gnt1 !== exp_g[c] || out_valid1 !== (exp_g[c] != 8'h00)) begin
                failures++;
                $display("FAIL burst1_cycle%0d gnt=%h valid=%b want gnt=%h", c, gnt1, out_valid1, exp_g[c]);
            end
        end
    endtask

    initial begin
        rst = 1'b1;
        req = '0;
        out_ready = 1'b0;
        for (int i = 0; i < 8; i++) data_in[i*16 +: 16] = 16'(16'hC000 + i);
        test_reset();
        test_single();
        data_in[15:0] = 16'hC000;
        test_round_robin();
        test_release_wrap();
        test_stall();
        test_reset_mid_burst();
        test_burst1();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
